// File: rtl/imm_pkg.sv
// ============================================================================
// Module      : imm_pkg
// Description : Shared immediate-extension mode encodings and default widths.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package imm_pkg;

    localparam int IMM_IN_W  = 16;
    localparam int IMM_OUT_W = 32;

    typedef enum logic [1:0] {
        MODE_SEXT = 2'b00,
        MODE_ZEXT = 2'b01,
        MODE_SHL  = 2'b10,
        MODE_LUI  = 2'b11
    } imm_mode_t;

endpackage

`default_nettype wire

// File: rtl/imm_ext_core.sv
// ============================================================================
// Module      : imm_ext_core
// Description : Combinational immediate extender (sign/zero/shifted/upper).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module imm_ext_core
    import imm_pkg::*;
#(
    parameter int IN_W  = IMM_IN_W,
    parameter int OUT_W = IMM_OUT_W,
    parameter int SHAMT = 2
) (
    input  logic [IN_W-1:0]  in_imm,
    input  imm_mode_t        in_mode,
    output logic [OUT_W-1:0] out_imm
);

    logic [OUT_W-1:0] w_sext;
    logic [OUT_W-1:0] w_zext;
    logic [OUT_W-1:0] w_lui;
    logic [OUT_W-1:0] w_shl;

    // Build by overlay so IN_W == OUT_W needs no zero-width replication.
    always_comb begin
        w_sext                 = {OUT_W{in_imm[IN_W-1]}};
        w_sext[IN_W-1:0]       = in_imm;
        w_zext                 = '0;
        w_zext[IN_W-1:0]       = in_imm;
        w_lui                  = '0;
        w_lui[OUT_W-1 -: IN_W] = in_imm;
        w_shl                  = w_sext << SHAMT;
    end

    always_comb begin
        out_imm = w_sext;
        case (in_mode)
            MODE_SEXT: out_imm = w_sext;
            MODE_ZEXT: out_imm = w_zext;
            MODE_SHL:  out_imm = w_shl;
            MODE_LUI:  out_imm = w_lui;
            default:   out_imm = w_sext;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/imm_ext_pipe.sv
// ============================================================================
// Module      : imm_ext_pipe
// Description : Immediate extender with valid/ready handshake and 2-entry FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module imm_ext_pipe
    import imm_pkg::*;
#(
    parameter int IN_W  = IMM_IN_W,
    parameter int OUT_W = IMM_OUT_W,
    parameter int SHAMT = 2,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_imm,
    input  logic [1:0]       in_mode,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_imm,
    output logic [TAG_W-1:0] out_tag
);

    logic [OUT_W-1:0] w_ext;
    logic             w_push;
    logic             w_pop;
    logic [1:0]       w_count_next;

    logic [OUT_W-1:0] r_mem_imm [2];
    logic [TAG_W-1:0] r_mem_tag [2];
    logic             r_wptr;
    logic             r_rptr;
    logic [1:0]       r_count;
    logic             r_in_ready;

    imm_ext_core #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W),
        .SHAMT (SHAMT)
    ) u_core (
        .in_imm  (in_imm),
        .in_mode (imm_mode_t'(in_mode)),
        .out_imm (w_ext)
    );

    assign w_push = in_valid && r_in_ready;
    assign w_pop  = (r_count != 2'd0) && out_ready;

    always_comb begin
        w_count_next = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_next = r_count + 2'd1;
            2'b01:   w_count_next = r_count - 2'd1;
            default: w_count_next = r_count;
        endcase
    end

    // Storage is reset too so the head entry reads zero while in reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem_imm[0] <= '0;
            r_mem_imm[1] <= '0;
            r_mem_tag[0] <= '0;
            r_mem_tag[1] <= '0;
            r_wptr       <= 1'b0;
            r_rptr       <= 1'b0;
            r_count      <= 2'd0;
            r_in_ready   <= 1'b0;
        end else begin
            if (w_push) begin
                r_mem_imm[r_wptr] <= w_ext;
                r_mem_tag[r_wptr] <= in_tag;
                r_wptr            <= ~r_wptr;
            end
            if (w_pop) begin
                r_rptr <= ~r_rptr;
            end
            r_count    <= w_count_next;
            r_in_ready <= (w_count_next < 2'd2);
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = (r_count != 2'd0);
    assign out_imm   = r_mem_imm[r_rptr];
    assign out_tag   = r_mem_tag[r_rptr];

endmodule

`default_nettype wire

// File: doc/imm_ext_pipe.md
Name: imm_ext_pipe

Overview:
Parametrised, pipelined immediate-generation unit for the decode stage. It extends an IN_W-bit instruction immediate to OUT_W bits in one of four modes: sign, zero, sign plus word-offset shift, and load-upper. A valid/ready handshake and a 2-entry output buffer absorb execute-stage stalls. It supersedes fixed 16-to-32 sign extension wherever immediates are produced.

Parameters:
IN_W, 16, immediate input width; must satisfy 1 <= IN_W <= OUT_W
OUT_W, 32, extended output width
SHAMT, 2, left-shift amount for MODE_SHL (branch/jump word offsets); must satisfy 0 <= SHAMT < OUT_W
TAG_W, 5, width of sideband tag (e.g. destination register index) carried alongside each immediate

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous, active-low reset
in_valid  input  1  in_imm/in_mode/in_tag valid this cycle
in_ready  output  1  unit can accept; transfer occurs when in_valid && in_ready
in_imm  input  IN_W  raw immediate field
in_mode  input  2  extension mode (see package constants)
in_tag  input  TAG_W  sideband tag, passed through unchanged
out_valid  output  1  out_imm/out_tag hold a valid result
out_ready  input  1  consumer accepts; transfer occurs when out_valid && out_ready
out_imm  output  OUT_W  extended immediate
out_tag  output  TAG_W  tag matching out_imm

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-low (clk, rst_n).
- While rst_n=0: buffer count=0, out_valid=0, in_ready=0, out_imm=0, out_tag=0.
- First cycle after reset release: in_ready=1.
- Mode arithmetic, computed combinationally before the buffer write. All results are truncated to OUT_W.
  - MODE_SEXT (2'b00): {(OUT_W-IN_W) copies of in_imm[IN_W-1], in_imm}.
  - MODE_ZEXT (2'b01): {(OUT_W-IN_W) zeros, in_imm}.
  - MODE_SHL (2'b10): sign-extended value shifted left by SHAMT; bits above OUT_W-1 are discarded.
  - MODE_LUI (2'b11): in_imm placed in bits [OUT_W-1 : OUT_W-IN_W], lower bits zero.
  - When IN_W == OUT_W: SEXT and ZEXT pass the input through unchanged, and LUI equals ZEXT.
- Buffer: 2-entry FIFO of {result, tag}, with registered read/write pointers (1 bit each) and a 2-bit count.
- Latency: an input accepted at edge N appears on out_* after edge N, provided the buffer was empty. Output order always equals input order.
- out_valid = (count != 0). out_imm/out_tag are driven from the head entry.
- Outputs hold stable while out_valid=1 && out_ready=0.
- in_ready is registered and equals (count_next < 2). It is therefore 0 in the cycle after the buffer becomes full; there is no combinational path from out_ready to in_ready.
- Simultaneous push and pop: count unchanged, both pointers advance. This is legal at count=1. At count=2 no push can occur, so a pop leaves count=1 with in_ready=1 on the next cycle.
- in_valid=1 while in_ready=0: inputs are ignored and no state changes. The producer must hold its inputs stable until accepted.
- Reset asserted mid-operation: buffered entries are discarded immediately and outputs return to reset values asynchronously.
- in_mode is sampled only on a transfer cycle. The mode has no effect on out_* timing.

Decomposition:
- Shared package imm_pkg holds:
  - typedef imm_mode_t (2-bit enum);
  - constants MODE_SEXT, MODE_ZEXT, MODE_SHL, MODE_LUI;
  - default widths IMM_IN_W=16 and IMM_OUT_W=32.
- One natural sub-module: imm_ext_core. It is purely combinational: in_imm and in_mode in, OUT_W result out, parametrised by IN_W/OUT_W/SHAMT, and reusable standalone in the ALU-immediate path.
- The FIFO and handshake logic stay in imm_ext_pipe.

Test Plan:
1. Defaults, out_ready=1:
   - SEXT 0x8001 -> 0xFFFF8001
   - SEXT 0x7FFF -> 0x00007FFF
   - ZEXT 0x8001 -> 0x00008001
   - Each result appears one cycle after acceptance.
2. Shift and upper modes:
   - SHL 0xFFFF -> 0xFFFFFFFC
   - SHL 0x4000 -> 0x00010000
   - LUI 0x1234 -> 0x12340000
   - out_tag echoes each in_tag (e.g. 5'd17 -> 5'd17).
3. Backpressure: hold out_ready=0 and present 3 back-to-back inputs (tags 1, 2, 3).
   - in_ready goes 0 after the 2nd acceptance and the 3rd input stalls.
   - Release out_ready: outputs arrive in order 1, 2, 3, with no loss and no duplication.
4. Streaming with alternating out_ready (1, 0, 1, 0 ...) and continuous in_valid for 20 items:
   - All 20 are delivered in order.
   - Push and pop in the same cycle at count=1 leave count at 1.
5. Reset mid-operation: with 2 entries buffered, pulse rst_n low between clock edges.
   - out_valid falls immediately, without waiting for a clock edge.
   - After release, no stale data is emitted and the first new input returns the correct result.
6. Parameter sweep with IN_W=12, OUT_W=32, SHAMT=1:
   - SEXT 0x800 -> 0xFFFFF800
   - SHL 0x801 -> 0xFFFFF002
   - LUI 0xABC -> 0xABC00000
   - With IN_W=OUT_W=32, SEXT passes 0x80000000 unchanged.
